// File: rtl/bcd_updown_cnt.sv
// Two-digit BCD up/down counter with clock prescaler and synchronous load.
// Define BCD_CNT_SATURATE_EN to make the counter hold at its bounds instead of wrapping; carry is then tied to 0.
module bcd_updown_cnt #(
  parameter int unsigned PRESCALE = 50_000_000,
  parameter logic [7:0]  LIMIT    = 8'h99
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       up,
  input  logic       load,
  input  logic [7:0] load_val,
  output logic [3:0] bcd_ones,
  output logic [3:0] bcd_tens,
  output logic       tick,
  output logic       carry
);

  localparam int unsigned    PW        = 26;
  localparam logic [PW-1:0]  PCNT_MAX  = PW'(PRESCALE - 1);
  localparam logic [3:0]     LIM_TENS  = LIMIT[7:4];
  localparam logic [3:0]     LIM_ONES  = LIMIT[3:0];

  logic [PW-1:0] pcnt;
  logic          pcnt_last;
  logic          step;
  logic [3:0]    nxt_ones;
  logic [3:0]    nxt_tens;
  logic          load_ok;
  logic          at_zero;
  logic          at_limit;
  logic          over_limit;

  // Digit-wise magnitude compare against LIMIT; no binary conversion.
  function automatic logic above_limit(input logic [3:0] tens, input logic [3:0] ones);
    return (tens > LIM_TENS) || ((tens == LIM_TENS) && (ones > LIM_ONES));
  endfunction

  assign pcnt_last  = (pcnt == PCNT_MAX);
  assign step       = en && pcnt_last && !load;
  assign at_zero    = (bcd_tens == 4'd0) && (bcd_ones == 4'd0);
  assign at_limit   = (bcd_tens == LIM_TENS) && (bcd_ones == LIM_ONES);
  assign over_limit = above_limit(bcd_tens, bcd_ones);

  assign load_ok = (load_val[7:4] <= 4'd9) && (load_val[3:0] <= 4'd9) &&
                   !above_limit(load_val[7:4], load_val[3:0]);

`ifndef BCD_CNT_SATURATE_EN
  logic wrap;
`endif

  // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    nxt_ones = bcd_ones;
    nxt_tens = bcd_tens;
`ifndef BCD_CNT_SATURATE_EN
    wrap     = 1'b0;
`endif
    if (up) begin
      if (over_limit) begin
        nxt_ones = 4'd0;
        nxt_tens = 4'd0;
      end else if (at_limit) begin
`ifndef BCD_CNT_SATURATE_EN
        nxt_ones = 4'd0;
        nxt_tens = 4'd0;
        wrap     = 1'b1;
`endif
      end else if (bcd_ones == 4'd9) begin
        nxt_ones = 4'd0;
        nxt_tens = bcd_tens + 4'd1;
      end else begin
        nxt_ones = bcd_ones + 4'd1;
      end
    end else begin
      if (at_zero) begin
`ifndef BCD_CNT_SATURATE_EN
        nxt_ones = LIM_ONES;
        nxt_tens = LIM_TENS;
        wrap     = 1'b1;
`endif
      end else if (bcd_ones == 4'd0) begin
        nxt_ones = 4'd9;
        nxt_tens = bcd_tens - 4'd1;
      end else begin
        nxt_ones = bcd_ones - 4'd1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together on the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pcnt     <= '0;
      bcd_ones <= 4'd0;
      bcd_tens <= 4'd0;
      tick     <= 1'b0;
    end else begin
      tick <= step;
      if (load) begin
        pcnt     <= '0;
        bcd_ones <= load_ok ? load_val[3:0] : 4'd0;
        bcd_tens <= load_ok ? load_val[7:4] : 4'd0;
      end else if (en) begin
        pcnt <= pcnt_last ? '0 : pcnt + 1'b1;
        if (pcnt_last) begin
          bcd_ones <= nxt_ones;
          bcd_tens <= nxt_tens;
        end
      end
    end
  end

`ifdef BCD_CNT_SATURATE_EN
  assign carry = 1'b0;
`else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      carry <= 1'b0;
    end else begin
      carry <= step && wrap;
    end
  end
`endif

  // Downstream decoders must never see a non-BCD digit.
  assert property (@(posedge clk) disable iff (!rst_n)
    (bcd_ones <= 4'd9) && (bcd_tens <= 4'd9));

  assert property (@(posedge clk) disable iff (!rst_n) carry |-> tick);

endmodule

// File: tb/tb_bcd_updown_cnt.sv
// Directed bench for bcd_updown_cnt with PRESCALE = 4 and LIMIT = 8'h59.
// Expected values follow BCD_CNT_SATURATE_EN when it is defined for the build.
module tb_bcd_updown_cnt;

  localparam int unsigned PRESCALE  = 4;
  localparam logic [7:0]  LIMIT     = 8'h59;
  localparam int          LIMIT_DEC = 59;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic       up;
  logic       load;
  logic [7:0] load_val;
  logic [3:0] bcd_ones;
  logic [3:0] bcd_tens;
  logic       tick;
  logic       carry;

  int total = 0;
  int bad   = 0;
  int model_v;

  typedef struct packed {
    logic       en;
    logic       up;
    logic       load;
    logic [7:0] lv;
    logic [7:0] val;
    logic       tk;
    logic       cy;
  } vec_t;

  localparam int NVEC = 18;
  vec_t vecs [NVEC];

  bcd_updown_cnt #(
    .PRESCALE (PRESCALE),
    .LIMIT    (LIMIT)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .up       (up),
    .load     (load),
    .load_val (load_val),
    .bcd_ones (bcd_ones),
    .bcd_tens (bcd_tens),
    .tick     (tick),
    .carry    (carry)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [7:0] to_bcd(input int v);
    logic [3:0] t;
    logic [3:0] o;
    t = 4'(v / 10);
    o = 4'(v % 10);
    return {t, o};
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_out(input string name, input logic [7:0] val, input logic tk, input logic cy);
    check({name, "_val"},   {bcd_tens, bcd_ones}, val);
    check({name, "_tick"},  8'(tick), 8'(tk));
    check({name, "_carry"}, 8'(carry), 8'(cy));
    check({name, "_bcd_ok"}, 8'((bcd_ones <= 4'd9) && (bcd_tens <= 4'd9)), 8'd1);
  endtask

  // Drive inputs just after an edge, then sample 1 ns after the next rising edge.
  task automatic cyc(input logic e, input logic u, input logic l, input logic [7:0] lv);
    en       = e;
    up       = u;
    load     = l;
    load_val = lv;
    @(posedge clk);
    #1;
  endtask

  // Runs n full prescale intervals from pcnt = 0, tracking the value as a decimal integer.
  task automatic run_steps(input int n, input logic dir);
    logic wrapped;
    for (int s = 0; s < n; s++) begin
      for (int c = 0; c < int'(PRESCALE) - 1; c++) begin
        cyc(1'b1, dir, 1'b0, 8'h00);
        check_out($sformatf("%s_wait%0d", dir ? "up" : "dn", model_v), to_bcd(model_v), 1'b0, 1'b0);
      end
      wrapped = 1'b0;
      if (dir) begin
        if (model_v == LIMIT_DEC) begin
`ifndef BCD_CNT_SATURATE_EN
          model_v = 0;
          wrapped = 1'b1;
`endif
        end else begin
          model_v++;
        end
      end else begin
        if (model_v == 0) begin
`ifndef BCD_CNT_SATURATE_EN
          model_v = LIMIT_DEC;
          wrapped = 1'b1;
`endif
        end else begin
          model_v--;
        end
      end
      cyc(1'b1, dir, 1'b0, 8'h00);
      check_out($sformatf("%s_step%0d", dir ? "up" : "dn", model_v), to_bcd(model_v), 1'b1, wrapped);
    end
  endtask

  initial begin
    //            en    up    load  lv     val    tick  carry
    vecs[0]  = '{1'b0, 1'b1, 1'b1, 8'h58, 8'h58, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 1'b1, 1'b0, 8'h00, 8'h58, 1'b0, 1'b0};
    vecs[2]  = '{1'b1, 1'b1, 1'b0, 8'h00, 8'h58, 1'b0, 1'b0};
    vecs[3]  = '{1'b1, 1'b1, 1'b0, 8'h00, 8'h58, 1'b0, 1'b0};
    vecs[4]  = '{1'b1, 1'b1, 1'b1, 8'h42, 8'h42, 1'b0, 1'b0};  // load on a step cycle
    vecs[5]  = '{1'b1, 1'b0, 1'b0, 8'h00, 8'h42, 1'b0, 1'b0};  // up toggles between steps
    vecs[6]  = '{1'b1, 1'b0, 1'b0, 8'h00, 8'h42, 1'b0, 1'b0};
    vecs[7]  = '{1'b1, 1'b1, 1'b0, 8'h00, 8'h42, 1'b0, 1'b0};
    vecs[8]  = '{1'b1, 1'b1, 1'b0, 8'h00, 8'h43, 1'b1, 1'b0};
    vecs[9]  = '{1'b0, 1'b1, 1'b1, 8'h7A, 8'h00, 1'b0, 1'b0};
    vecs[10] = '{1'b0, 1'b1, 1'b1, 8'h55, 8'h55, 1'b0, 1'b0};
    vecs[11] = '{1'b0, 1'b1, 1'b1, 8'h60, 8'h00, 1'b0, 1'b0};
    vecs[12] = '{1'b0, 1'b1, 1'b1, 8'h59, 8'h59, 1'b0, 1'b0};
    vecs[13] = '{1'b0, 1'b1, 1'b1, 8'hA0, 8'h00, 1'b0, 1'b0};
    vecs[14] = '{1'b1, 1'b0, 1'b1, 8'h59, 8'h59, 1'b0, 1'b0};
    vecs[15] = '{1'b1, 1'b1, 1'b0, 8'h00, 8'h59, 1'b0, 1'b0};
    vecs[16] = '{1'b1, 1'b1, 1'b0, 8'h00, 8'h59, 1'b0, 1'b0};
    vecs[17] = '{1'b1, 1'b1, 1'b0, 8'h00, 8'h59, 1'b0, 1'b0};

    en = 1'b0; up = 1'b1; load = 1'b0; load_val = 8'h00;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check_out("por", 8'h00, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 8'h00);
    cyc(1'b0, 1'b1, 1'b0, 8'h00);
    rst_n = 1'b1;

    // Reset asserted mid-count while tick is high clears everything without a clock edge.
    cyc(1'b0, 1'b1, 1'b1, 8'h37);
    check_out("load37", 8'h37, 1'b0, 1'b0);
    model_v = 37;
    run_steps(1, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check_out("rst_async", 8'h00, 1'b0, 1'b0);
    @(negedge clk);
    rst_n   = 1'b1;
    model_v = 0;

    // First step lands on the 4th enabled edge; then full up sweep through 09->10 and 59->00.
    run_steps(1, 1'b1);
    run_steps(61, 1'b1);

    // Down count from 10 through 00 and past the lower bound.
    cyc(1'b1, 1'b0, 1'b1, 8'h10);
    check_out("load10", 8'h10, 1'b0, 1'b0);
    model_v = 10;
    run_steps(12, 1'b0);

    for (int i = 0; i < NVEC; i++) begin
      cyc(vecs[i].en, vecs[i].up, vecs[i].load, vecs[i].lv);
      check_out($sformatf("vec%0d", i), vecs[i].val, vecs[i].tk, vecs[i].cy);
    end

    // pcnt is now 3 at value 59: a 10-cycle enable gap must suppress the step.
    for (int i = 0; i < 10; i++) begin
      cyc(1'b0, 1'b1, 1'b0, 8'h00);
      check_out($sformatf("gap%0d", i), 8'h59, 1'b0, 1'b0);
    end
    cyc(1'b1, 1'b1, 1'b0, 8'h00);
`ifdef BCD_CNT_SATURATE_EN
    check_out("gap_resume", 8'h59, 1'b1, 1'b0);
`else
    check_out("gap_resume", 8'h00, 1'b1, 1'b1);
`endif
    cyc(1'b1, 1'b1, 1'b0, 8'h00);
`ifdef BCD_CNT_SATURATE_EN
    check_out("after_resume", 8'h59, 1'b0, 1'b0);
`else
    check_out("after_resume", 8'h00, 1'b0, 1'b0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
